// File: rtl/tpu_seq_pkg.sv
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared types, CSR bit positions and sizing helpers for tpu_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  typedef enum logic [1:0] {RD_ZERO = 2'd0, RD_C = 2'd1, RD_STATUS = 2'd2} rd_sel_t;

  typedef enum logic [2:0] {
    REG_NONE   = 3'd0,
    REG_A      = 3'd1,
    REG_B      = 3'd2,
    REG_C      = 3'd3,
    REG_CTRL   = 3'd4,
    REG_STATUS = 3'd5
  } region_t;

  localparam int CTRL_START = 0;
  localparam int CTRL_ACC   = 1;
  localparam int CTRL_CLR   = 2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;

  // Number of host words per C row.
  function automatic int calc_cw(int dim, int bits_c, int dataw);
    return bits_c * dim / dataw;
  endfunction

  // Wavefront length through a DIM x DIM skewed systolic array.
  function automatic int run_cycles(int dim);
    return 3 * dim - 2;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_seq_if.sv
// ============================================================================
// Module   : tpu_seq_if
// Purpose  : Host-side access bus of the matrix-multiply sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tpu_seq_if #(
  parameter int ADDRW = 16
);
  logic             req;
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic [2:0]       wdata_ctl;
  logic             ack;
  logic             err;
  logic [1:0]       rd_sel;
  logic [2:0]       status;

  modport master (output req, r_w, addr, wdata_ctl, input ack, err, rd_sel, status);
  modport slave  (input req, r_w, addr, wdata_ctl, output ack, err, rd_sel, status);
endinterface

`default_nettype wire

// File: rtl/tpu_seq_addr_dec.sv
// ============================================================================
// Module   : tpu_addr_dec
// Purpose  : Combinational host address decode into region, row and C word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tpu_addr_dec
  import tpu_pkg::*;
#(
  parameter int               DIM      = 8,
  parameter int               BITS_C   = 16,
  parameter int               DATAW    = 64,
  parameter int               ADDRW    = 16,
  parameter logic [ADDRW-1:0] BASE_A   = ADDRW'('h0100),
  parameter logic [ADDRW-1:0] BASE_B   = ADDRW'('h0200),
  parameter logic [ADDRW-1:0] BASE_C   = ADDRW'('h0300),
  parameter logic [ADDRW-1:0] BASE_CSR = ADDRW'('h0400)
) (
  input  wire logic [ADDRW-1:0]                             i_addr,
  output region_t                                           o_region,
  output logic [idx_w(DIM)-1:0]                             o_row,
  output logic [idx_w(calc_cw(DIM, BITS_C, DATAW))-1:0]     o_word
);
  localparam int c_W   = DATAW / 8;
  localparam int c_WB  = $clog2(c_W);
  localparam int c_CW  = calc_cw(DIM, BITS_C, DATAW);
  localparam int c_CWB = $clog2(c_CW);
  localparam int c_RW  = idx_w(DIM);
  localparam int c_CWW = idx_w(c_CW);
  localparam logic [ADDRW-1:0] c_SPAN_AB = ADDRW'(DIM * c_W);
  localparam logic [ADDRW-1:0] c_SPAN_C  = ADDRW'(DIM * c_CW * c_W);
  localparam logic [ADDRW-1:0] c_STATUS  = BASE_CSR + ADDRW'(c_W);

  // Offsets wrap below each base, so a single unsigned compare bounds the region.
  logic [ADDRW-1:0] w_off_a;
  logic [ADDRW-1:0] w_off_b;
  logic [ADDRW-1:0] w_off_c;
  logic             w_aligned;

  assign w_off_a   = i_addr - BASE_A;
  assign w_off_b   = i_addr - BASE_B;
  assign w_off_c   = i_addr - BASE_C;
  assign w_aligned = (i_addr[c_WB-1:0] == '0);

  always_comb begin
    o_region = REG_NONE;
    o_row    = '0;
    o_word   = '0;
    if (w_aligned) begin
      if (w_off_a < c_SPAN_AB) begin
        o_region = REG_A;
        o_row    = c_RW'(w_off_a >> c_WB);
      end else if (w_off_b < c_SPAN_AB) begin
        o_region = REG_B;
        o_row    = c_RW'(w_off_b >> c_WB);
      end else if (w_off_c < c_SPAN_C) begin
        o_region = REG_C;
        o_row    = c_RW'(w_off_c >> (c_WB + c_CWB));
        o_word   = c_CWW'(w_off_c >> c_WB);
      end else if (i_addr == BASE_CSR) begin
        o_region = REG_CTRL;
      end else if (i_addr == c_STATUS) begin
        o_region = REG_STATUS;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tpu_seq.sv
// ============================================================================
// Module   : tpu_seq
// Purpose  : Memory-mapped sequencer driving memA/memB/systolic/C control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tpu_seq
  import tpu_pkg::*;
#(
  parameter int               DIM      = 8,
  parameter int               BITS_C   = 16,
  parameter int               DATAW    = 64,
  parameter int               ADDRW    = 16,
  parameter logic [ADDRW-1:0] BASE_A   = ADDRW'('h0100),
  parameter logic [ADDRW-1:0] BASE_B   = ADDRW'('h0200),
  parameter logic [ADDRW-1:0] BASE_C   = ADDRW'('h0300),
  parameter logic [ADDRW-1:0] BASE_CSR = ADDRW'('h0400)
) (
  input  wire logic                                         clk,
  input  wire logic                                         rst,
  tpu_seq_if.slave                                          bus,
  output logic                                              a_en,
  output logic [idx_w(DIM)-1:0]                             a_row,
  output logic                                              b_en,
  output logic                                              sys_en,
  output logic                                              c_wr,
  output logic [idx_w(DIM)-1:0]                             c_row,
  output logic [idx_w(calc_cw(DIM, BITS_C, DATAW))-1:0]     c_word,
  output logic                                              c_clr,
  output logic                                              busy,
  output logic                                              done
);
  localparam int c_RW   = idx_w(DIM);
  localparam int c_CWW  = idx_w(calc_cw(DIM, BITS_C, DATAW));
  localparam int c_CNTW = $clog2(3 * DIM);
  localparam logic [c_CNTW-1:0] c_RUN_LAST = c_CNTW'(run_cycles(DIM) - 1);
  localparam logic [c_CNTW-1:0] c_ROW_LAST = c_CNTW'(DIM - 1);

  region_t          w_region;
  logic [c_RW-1:0]  w_row;
  logic [c_CWW-1:0] w_word;

  tpu_addr_dec #(
    .DIM(DIM), .BITS_C(BITS_C), .DATAW(DATAW), .ADDRW(ADDRW),
    .BASE_A(BASE_A), .BASE_B(BASE_B), .BASE_C(BASE_C), .BASE_CSR(BASE_CSR)
  ) u_dec (
    .i_addr  (bus.addr),
    .o_region(w_region),
    .o_row   (w_row),
    .o_word  (w_word)
  );

  state_t           r_state,  w_st_nxt;
  logic [c_CNTW-1:0] r_cnt,   w_cnt_nxt;
  logic             r_ack,    w_ack_nxt;
  logic             r_err,    w_err_nxt;
  rd_sel_t          r_rd_sel, w_rd_sel_nxt;
  logic             r_a_en,   w_a_en_nxt;
  logic [c_RW-1:0]  r_a_row,  w_a_row_nxt;
  logic             r_b_en,   w_b_en_nxt;
  logic             r_sys_en, w_sys_en_nxt;
  logic             r_c_wr,   w_c_wr_nxt;
  logic [c_RW-1:0]  r_c_row,  w_c_row_nxt;
  logic [c_CWW-1:0] r_c_word, w_c_word_nxt;
  logic             r_c_clr,  w_c_clr_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_sticky, w_sticky_nxt;
  logic [c_CNTW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rd_sel <= RD_ZERO;
      r_a_en   <= 1'b0;
      r_a_row  <= '0;
      r_b_en   <= 1'b0;
      r_sys_en <= 1'b0;
      r_c_wr   <= 1'b0;
      r_c_row  <= '0;
      r_c_word <= '0;
      r_c_clr  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_st_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_rd_sel <= w_rd_sel_nxt;
      r_a_en   <= w_a_en_nxt;
      r_a_row  <= w_a_row_nxt;
      r_b_en   <= w_b_en_nxt;
      r_sys_en <= w_sys_en_nxt;
      r_c_wr   <= w_c_wr_nxt;
      r_c_row  <= w_c_row_nxt;
      r_c_word <= w_c_word_nxt;
      r_c_clr  <= w_c_clr_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  always_comb begin
    w_st_nxt     = r_state;
    w_cnt_nxt    = r_cnt;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_rd_sel_nxt = RD_ZERO;
    w_a_en_nxt   = 1'b0;
    w_a_row_nxt  = '0;
    w_b_en_nxt   = 1'b0;
    w_sys_en_nxt = 1'b0;
    w_c_wr_nxt   = 1'b0;
    w_c_row_nxt  = '0;
    w_c_word_nxt = '0;
    w_c_clr_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_sticky_nxt = r_sticky;

    case (r_state)
      RUN: begin
        if (r_cnt == c_RUN_LAST) begin
          w_st_nxt   = DONE;
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt    = w_cnt_inc;
          w_a_en_nxt   = 1'b1;
          w_b_en_nxt   = 1'b1;
          w_sys_en_nxt = 1'b1;
          w_a_row_nxt  = (w_cnt_inc >= c_ROW_LAST) ? c_RW'(DIM - 1) : c_RW'(w_cnt_inc);
        end
        // Only STATUS reads are served while the array is running.
        if (bus.req) begin
          w_ack_nxt = 1'b1;
          if (w_region == REG_STATUS && !bus.r_w) w_rd_sel_nxt = RD_STATUS;
          else                                    w_err_nxt    = 1'b1;
        end
      end
      default: begin
        if (bus.req) begin
          w_ack_nxt = 1'b1;
          case (w_region)
            REG_A: begin
              if (bus.r_w) begin
                w_a_en_nxt  = 1'b1;
                w_a_row_nxt = w_row;
              end else w_err_nxt = 1'b1;
            end
            REG_B: begin
              if (bus.r_w) w_b_en_nxt = 1'b1;
              else         w_err_nxt  = 1'b1;
            end
            REG_C: begin
              w_c_row_nxt  = w_row;
              w_c_word_nxt = w_word;
              if (bus.r_w) w_c_wr_nxt   = 1'b1;
              else         w_rd_sel_nxt = RD_C;
            end
            REG_STATUS: begin
              if (!bus.r_w) w_rd_sel_nxt = RD_STATUS;
            end
            REG_CTRL: begin
              if (bus.r_w) begin
                if (bus.wdata_ctl == 3'b000) w_sticky_nxt = 1'b0;
                if (bus.wdata_ctl[CTRL_CLR]) w_c_clr_nxt = 1'b1;
                // The start cycle is the first RUN cycle, so any clear merges into one pulse.
                if (bus.wdata_ctl[CTRL_START]) begin
                  w_st_nxt     = RUN;
                  w_cnt_nxt    = '0;
                  w_busy_nxt   = 1'b1;
                  w_done_nxt   = 1'b0;
                  w_a_en_nxt   = 1'b1;
                  w_b_en_nxt   = 1'b1;
                  w_sys_en_nxt = 1'b1;
                  w_a_row_nxt  = '0;
                  if (!bus.wdata_ctl[CTRL_ACC]) w_c_clr_nxt = 1'b1;
                end
              end
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
    endcase

    if (w_err_nxt) w_sticky_nxt = 1'b1;
  end

  assign bus.ack    = r_ack;
  assign bus.err    = r_err;
  assign bus.rd_sel = r_rd_sel;
  assign bus.status = {r_sticky, r_done, r_busy};
  assign a_en       = r_a_en;
  assign a_row      = r_a_row;
  assign b_en       = r_b_en;
  assign sys_en     = r_sys_en;
  assign c_wr       = r_c_wr;
  assign c_row      = r_c_row;
  assign c_word     = r_c_word;
  assign c_clr      = r_c_clr;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tpu_seq.sv
// ============================================================================
// Module   : tb_tpu_seq
// Purpose  : Directed self-checking bench for the tpu_seq sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tpu_seq;
  logic       clk;
  logic       rst;
  logic       a_en, b_en, sys_en, c_wr, c_clr, busy, done;
  logic [2:0] a_row, c_row;
  logic [0:0] c_word;
  int         n_checks;
  int         n_fail;

  tpu_seq_if #(.ADDRW(16)) bus ();

  tpu_seq dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .a_en  (a_en),
    .a_row (a_row),
    .b_en  (b_en),
    .sys_en(sys_en),
    .c_wr  (c_wr),
    .c_row (c_row),
    .c_word(c_word),
    .c_clr (c_clr),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle host access; returns #1 after the edge that registers the response.
  task automatic access(input bit wr, input logic [15:0] a, input logic [2:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.r_w = wr; bus.addr = a; bus.wdata_ctl = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 1'b0; bus.r_w = 1'b0; bus.addr = '0; bus.wdata_ctl = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({bus.ack, bus.err, a_en, b_en, sys_en, c_wr, c_clr, busy, done} !== 9'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {bus.ack, bus.err, a_en, b_en, sys_en, c_wr, c_clr, busy, done}); end
    @(negedge clk); rst = 1'b0;
    access(1'b0, 16'h0408, 3'b0);
    n_checks++; if (bus.ack !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL status_ack: got ack=%b err=%b want 1/0", bus.ack, bus.err); end
    n_checks++; if (bus.rd_sel !== 2'd2) begin n_fail++; $display("FAIL status_rdsel: got %0d want 2", bus.rd_sel); end
    n_checks++; if (bus.status !== 3'b000) begin n_fail++; $display("FAIL status_reset_val: got %b want 000", bus.status); end
    @(posedge clk); #1;
    n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL ack_single: got %b want 0", bus.ack); end
  endtask

  task automatic test_host_writes();
    access(1'b1, 16'h0118, 3'b0);
    n_checks++; if ({a_en, a_row, bus.ack, bus.err, b_en} !== {1'b1, 3'd3, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL a_write: got a_en=%b row=%0d ack=%b err=%b b_en=%b want 1 3 1 0 0", a_en, a_row, bus.ack, bus.err, b_en); end
    access(1'b1, 16'h0328, 3'b0);
    n_checks++; if ({c_wr, c_row, c_word, bus.err} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL c_write: got c_wr=%b row=%0d word=%0d err=%b want 1 2 1 0", c_wr, c_row, c_word, bus.err); end
    access(1'b0, 16'h0318, 3'b0);
    n_checks++; if ({bus.rd_sel, c_row, c_word, c_wr} !== {2'd1, 3'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL c_read: got sel=%0d row=%0d word=%0d c_wr=%b want 1 1 1 0", bus.rd_sel, c_row, c_word, c_wr); end
    access(1'b1, 16'h0238, 3'b0);
    n_checks++; if ({b_en, a_en, bus.err} !== 3'b100) begin n_fail++; $display("FAIL b_write: got b_en=%b a_en=%b err=%b want 1 0 0", b_en, a_en, bus.err); end
    access(1'b1, 16'h0408 , 3'b0);
    n_checks++; if ({bus.ack, bus.err} !== 2'b10) begin n_fail++; $display("FAIL status_write: got ack=%b err=%b want 1 0", bus.ack, bus.err); end
  endtask

  task automatic test_errors();
    access(1'b1, 16'h0101, 3'b0);
    n_checks++; if ({bus.ack, bus.err, a_en} !== 3'b110) begin n_fail++; $display("FAIL misaligned: got ack=%b err=%b a_en=%b want 1 1 0", bus.ack, bus.err, a_en); end
    access(1'b1, 16'h0140, 3'b0);
    n_checks++; if ({bus.err, a_en} !== 2'b10) begin n_fail++; $display("FAIL a_past_end: got err=%b a_en=%b want 1 0", bus.err, a_en); end
    access(1'b0, 16'h0100, 3'b0);
    n_checks++; if ({bus.ack, bus.err, bus.rd_sel} !== 4'b1100) begin n_fail++; $display("FAIL a_read: got ack=%b err=%b sel=%0d want 1 1 0", bus.ack, bus.err, bus.rd_sel); end
    access(1'b1, 16'h0380, 3'b0);
    n_checks++; if ({bus.err, c_wr} !== 2'b10) begin n_fail++; $display("FAIL c_past_end: got err=%b c_wr=%b want 1 0", bus.err, c_wr); end
    access(1'b1, 16'h0400, 3'b000);
    access(1'b0, 16'h0408, 3'b0);
    n_checks++; if (bus.status !== 3'b000) begin n_fail++; $display("FAIL sticky_clear_idle: got %b want 000", bus.status); end
  endtask

  task automatic test_clear();
    access(1'b1, 16'h0400, 3'b100);
    n_checks++; if ({c_clr, busy, sys_en, bus.err} !== 4'b1000) begin n_fail++; $display("FAIL clear_only: got c_clr=%b busy=%b sys_en=%b err=%b want 1 0 0 0", c_clr, busy, sys_en, bus.err); end
    @(posedge clk); #1;
    n_checks++; if (c_clr !== 1'b0) begin n_fail++; $display("FAIL clear_pulse_len: got %b want 0", c_clr); end
  endtask

  task automatic test_run(input logic [2:0] ctl, input int exp_clr, input bit was_done);
    int n_sys, n_clr, n_row_bad;
    bit finished;
    n_sys = 0; n_clr = 0; n_row_bad = 0; finished = 1'b0;
    access(1'b1, 16'h0400, ctl);
    n_checks++; if ({bus.ack, bus.err, busy, done} !== 4'b1010) begin n_fail++; $display("FAIL run_start ctl=%0h: got ack=%b err=%b busy=%b done=%b want 1 0 1 0 (prev done %0b)", ctl, bus.ack, bus.err, busy, done, was_done); end
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin finished = 1'b1; break; end
      if (sys_en) begin
        if (a_row !== ((n_sys < 7) ? 3'(n_sys) : 3'd7) || a_en !== 1'b1 || b_en !== 1'b1) n_row_bad++;
        n_sys++;
      end
      if (c_clr) n_clr++;
      @(posedge clk); #1;
    end
    n_checks++; if (!finished) begin n_fail++; $display("FAIL run_timeout ctl=%0h: busy=%b after 40 cycles want 0", ctl, busy); end
    n_checks++; if (n_sys != 22) begin n_fail++; $display("FAIL run_len ctl=%0h: got %0d sys_en cycles want 22", ctl, n_sys); end
    n_checks++; if (n_clr != exp_clr) begin n_fail++; $display("FAIL run_clr ctl=%0h: got %0d c_clr pulses want %0d", ctl, n_clr, exp_clr); end
    n_checks++; if (n_row_bad != 0) begin n_fail++; $display("FAIL run_rows ctl=%0h: got %0d bad strobe cycles want 0", ctl, n_row_bad); end
    n_checks++; if ({done, busy, sys_en, a_en, b_en} !== 5'b10000) begin n_fail++; $display("FAIL run_end ctl=%0h: got done=%b busy=%b sys=%b a=%b b=%b want 1 0 0 0 0", ctl, done, busy, sys_en, a_en, b_en); end
  endtask

  task automatic test_busy_access();
    bit finished;
    finished = 1'b0;
    access(1'b1, 16'h0400, 3'b011);
    repeat (3) @(posedge clk);
    access(1'b1, 16'h0200, 3'b0);
    n_checks++; if ({bus.ack, bus.err, b_en, sys_en} !== 4'b1111) begin n_fail++; $display("FAIL busy_b_write: got ack=%b err=%b b_en=%b sys=%b want 1 1 1 1", bus.ack, bus.err, b_en, sys_en); end
    access(1'b0, 16'h0408, 3'b0);
    n_checks++; if ({bus.err, bus.rd_sel, bus.status} !== {1'b0, 2'd2, 3'b101}) begin n_fail++; $display("FAIL busy_status: got err=%b sel=%0d status=%b want 0 2 101", bus.err, bus.rd_sel, bus.status); end
    access(1'b1, 16'h0400, 3'b101);
    n_checks++; if ({bus.err, c_clr, busy} !== 3'b101) begin n_fail++; $display("FAIL busy_start: got err=%b c_clr=%b busy=%b want 1 0 1", bus.err, c_clr, busy); end
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin finished = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (!finished) begin n_fail++; $display("FAIL busy_timeout: busy=%b want 0", busy); end
    access(1'b1, 16'h0400, 3'b000);
    n_checks++; if ({bus.err, busy, sys_en} !== 3'b000) begin n_fail++; $display("FAIL ctrl_zero: got err=%b busy=%b sys=%b want 0 0 0", bus.err, busy, sys_en); end
    access(1'b0, 16'h0408, 3'b0);
    n_checks++; if (bus.status !== 3'b010) begin n_fail++; $display("FAIL sticky_cleared: got %b want 010", bus.status); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req = 1'b1; bus.r_w = 1'b1; bus.addr = 16'h0108; bus.wdata_ctl = 3'b0;
    @(posedge clk); #1;
    n_checks++; if ({bus.ack, a_en, a_row} !== {1'b1, 1'b1, 3'd1}) begin n_fail++; $display("FAIL b2b_first: got ack=%b a_en=%b row=%0d want 1 1 1", bus.ack, a_en, a_row); end
    bus.addr = 16'h0128;
    @(posedge clk); #1;
    bus.req = 1'b0;
    n_checks++; if ({bus.ack, a_en, a_row} !== {1'b1, 1'b1, 3'd5}) begin n_fail++; $display("FAIL b2b_second: got ack=%b a_en=%b row=%0d want 1 1 5", bus.ack, a_en, a_row); end
  endtask

  task automatic test_reset_mid_run();
    access(1'b1, 16'h0400, 3'b001);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({sys_en, a_en, b_en, busy, done, bus.ack} !== 6'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 000000", {sys_en, a_en, b_en, busy, done, bus.ack}); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({sys_en, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_no_resume: got sys=%b busy=%b want 0 0", sys_en, busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_host_writes();
    test_errors();
    test_clear();
    test_run(3'b001, 1, 1'b0);
    test_run(3'b011, 0, 1'b1);
    test_run(3'b101, 1, 1'b1);
    test_busy_access();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tpu_seq.md
Name: tpu_seq

Overview:
- Parametrised memory-mapped sequencer for the matrix-multiply unit.
- Decodes host bus accesses into control strobes for the A-row memory, the B-skew memory and the systolic array.
- Runs the multiply autonomously once started, with busy/done status, accumulate mode and error reporting.
- Sits between the host bus and the datapath. Data buses bypass it; it drives only control signals and the read-data select.

Parameters:
- DIM, 8, systolic array dimension (rows = cols).
- BITS_C, 16, accumulator width per C element.
- DATAW, 64, host data bus width.
- ADDRW, 16, host byte-address width.
- BASE_A, 16'h0100, base byte address of the A region.
- BASE_B, 16'h0200, base byte address of the B region.
- BASE_C, 16'h0300, base byte address of the C region.
- BASE_CSR, 16'h0400, base byte address of the control/status registers.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  host access request (single-cycle pulse).
- r_w  in  1  0 = read, 1 = write.
- addr  in  ADDRW  byte address.
- wdata_ctl  in  3  dataIn[2:0] for CSR writes: bit0 start, bit1 accumulate, bit2 clear_c.
- ack  out  1  access complete, one cycle after req.
- err  out  1  qualifies ack: access rejected.
- rd_sel  out  2  dataOut mux select: 0 zero, 1 C word, 2 STATUS.
- a_en  out  1  memA row write strobe.
- a_row  out  clog2(DIM)  memA row index.
- b_en  out  1  memB push/shift enable.
- sys_en  out  1  systolic array advance.
- c_wr  out  1  C word write strobe.
- c_row  out  clog2(DIM)  C row index.
- c_word  out  clog2(CW)  word within C row, where CW = BITS_C*DIM/DATAW.
- c_clr  out  1  clear all C accumulators.
- busy  out  1  multiply in progress.
- done  out  1  sticky completion flag.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; done = 0. A reset mid-multiply aborts the run immediately with no further strobes.
- Address decode, with W = DATAW/8:
  - A row r at BASE_A + r*W, r < DIM.
  - B row r at BASE_B + r*W.
  - C row r, word k at BASE_C + (r*CW + k)*W.
  - CTRL at BASE_CSR; STATUS at BASE_CSR + W.
  - Misaligned or unmapped addresses are errors.
- Handshake:
  - req is sampled at the clock edge; ack, err and the strobes are registered and asserted exactly 1 cycle later for 1 cycle.
  - req while ack is high is legal (back-to-back accesses).
- Host writes in IDLE/DONE:
  - A write: a_en = 1, a_row = r.
  - B write: b_en = 1. Rows are pushed in order; memB shifts, so the index is ignored.
  - C write: c_wr = 1 with c_row/c_word.
  - STATUS write: ignored, no error.
- Host reads:
  - C read: rd_sel = 1 with c_row/c_word.
  - STATUS read: rd_sel = 2, where STATUS = {err_sticky, done, busy} in bits [2:0].
  - A/B reads: ack with err = 1.
- CTRL write:
  - clear_c = 1: c_clr pulses for one cycle.
  - start = 1: done clears, then go to RUN. If accumulate = 0, c_clr also pulses on the first RUN cycle.
  - start and clear_c together: the clear is applied once (not twice).
- FSM states:
  - IDLE -> RUN on start.
  - RUN: busy = 1; a_en, b_en, sys_en are all 1 each cycle; a_row counts 0..DIM-1 then holds. Lasts 3*DIM-2 cycles, tracked by a counter of clog2(3*DIM) bits.
  - RUN -> DONE when the counter reaches 3*DIM-3. At that transition busy drops and done is set.
  - DONE -> RUN on a new start. Otherwise DONE behaves as IDLE.
- Access while busy:
  - Any access except a STATUS read gets err = 1 and err_sticky = 1, with no strobe.
  - A start while busy is ignored and flagged the same way.
- err_sticky is cleared only by reset or by a CTRL write with all bits 0.

Decomposition:
- Package tpu_pkg holds:
  - state_t enum {IDLE, RUN, DONE}.
  - rd_sel_t enum.
  - CSR bit-position localparams.
  - A function computing CW and RUN_CYCLES.
- Sub-module tpu_addr_dec: combinational region/index/error decode, parametrised by the bases.

Test Plan:
- Reset, then STATUS read -> ack = 1 one cycle later, rd_sel = 2, busy = 0, done = 0, err = 0.
- Write A row 3 at 0x0118 -> next cycle a_en = 1, a_row = 3, ack = 1, err = 0.
- Write C row 2, word 1 (DIM = 8, CW = 2) at 0x0328 -> c_wr = 1, c_row = 2, c_word = 1.
- CTRL write 0x1 -> c_clr pulse on the first RUN cycle; sys_en high for exactly 22 cycles; then busy = 0, done = 1.
- CTRL write 0x3 (accumulate) -> no c_clr pulse; same 22-cycle RUN.
- During RUN, write B at 0x0200 -> err = 1, no b_en beyond the RUN pattern; STATUS read -> 0b101 (err_sticky, busy); CTRL write 0x0 afterwards -> err_sticky cleared.
